// File: rtl/e_calc_pow.sv
`default_nettype none
// ============================================================================
// Module      : e_calc_pow
// Description : Multi-word fixed-point exponentiator, result = base ^ exp,
//               using left-to-right binary square-and-multiply. The
//               multiplier lives outside this block and is driven through a
//               start/done handshake so it can be shared with other engines.
//
//               Operand packing: word 0 (integer part) sits in the most
//               significant WORD_W bits, so each operand vector reads as an
//               unsigned fixed-point number with WORD_W*(WORDS-1) fraction
//               bits.
//
// Ports       : clk, rst_n         clock, asynchronous active-low reset
//               start, abort       request (IDLE only) / synchronous abort
//               exp_in, base_in    exponent and base, latched on start
//               busy, done         operation in flight / 1-cycle completion
//               result             working value, final once done pulses
//               mul_start/a/b      request and operands to the multiplier
//               mul_done/p         completion pulse and product from it
//               mul_cnt            (E_CALC_POW_CNT_EN only) multiply count
//
// Options     : define E_CALC_POW_CNT_EN to add the mul_cnt output.
// Revision    : 1.0  initial release
// ============================================================================
module e_calc_pow #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 32,
    parameter int EXP_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [WORD_W*WORDS-1:0] base_in,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    mul_start,
    output logic [WORD_W*WORDS-1:0] mul_a,
    output logic [WORD_W*WORDS-1:0] mul_b,
    input  logic                    mul_done,
    input  logic [WORD_W*WORDS-1:0] mul_p
`ifdef E_CALC_POW_CNT_EN
    ,
    output logic [EXP_W+1:0]        mul_cnt
`endif
);

    localparam int c_op_w = WORD_W * WORDS;
    localparam int c_k_w  = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    // Fixed-point 1.0: integer word = 1, all fraction words = 0.
    localparam logic [c_op_w-1:0] c_one   = {{(c_op_w-1){1'b0}}, 1'b1} << (c_op_w - WORD_W);
    localparam logic [c_k_w-1:0]  c_k_max = c_k_w'(EXP_W - 1);
    localparam logic [c_k_w-1:0]  c_k_one = c_k_w'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SQ_REQ   = 3'd2,
        S_SQ_WAIT  = 3'd3,
        S_MUL_REQ  = 3'd4,
        S_MUL_WAIT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              r_state;
    logic [c_op_w-1:0]   r_base;
    logic [EXP_W-1:0]    r_exp;
    logic [c_k_w-1:0]    r_k;
    logic                r_busy;
    logic                r_done;
    logic                r_mul_start;
    logic [c_op_w-1:0]   r_result;
    logic [c_op_w-1:0]   r_mul_a;
    logic [c_op_w-1:0]   r_mul_b;
`ifdef E_CALC_POW_CNT_EN
    logic [EXP_W+1:0]    r_mul_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_exp       <= '0;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mul_start <= 1'b0;
            r_result    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
`ifdef E_CALC_POW_CNT_EN
            r_mul_cnt   <= '0;
`endif
        end else begin
            // Both strobes are single-cycle by construction.
            r_done      <= 1'b0;
            r_mul_start <= 1'b0;

            if (abort && (r_state != S_IDLE)) begin
                // Partial result is kept; any product still in flight is
                // dropped because IDLE never looks at mul_done.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_base  <= base_in;
                            r_exp   <= exp_in;
                            r_k     <= c_k_max;
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
`ifdef E_CALC_POW_CNT_EN
                            r_mul_cnt <= '0;
`endif
                        end
                    end

                    // Leading-one search: the first set bit seeds the
                    // accumulator with the base, saving a multiply by 1.0.
                    S_LOAD: begin
                        if (r_exp[r_k]) begin
                            r_result <= r_base;
                            if (r_k == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_k     <= r_k - c_k_one;
                                r_state <= S_SQ_REQ;
                            end
                        end else if (r_k == '0) begin
                            r_result <= c_one;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_k <= r_k - c_k_one;
                        end
                    end

                    S_SQ_REQ: begin
                        r_mul_a     <= r_result;
                        r_mul_b     <= r_result;
                        r_mul_start <= 1'b1;
                        r_state     <= S_SQ_WAIT;
`ifdef E_CALC_POW_CNT_EN
                        r_mul_cnt   <= r_mul_cnt + 1'b1;
`endif
                    end

                    S_SQ_WAIT: begin
                        if (mul_done) begin
                            r_result <= mul_p;
                            if (r_exp[r_k]) begin
                                r_state <= S_MUL_REQ;
                            end else if (r_k == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_k     <= r_k - c_k_one;
                                r_state <= S_SQ_REQ;
                            end
                        end
                    end

                    S_MUL_REQ: begin
                        r_mul_a     <= r_result;
                        r_mul_b     <= r_base;
                        r_mul_start <= 1'b1;
                        r_state     <= S_MUL_WAIT;
`ifdef E_CALC_POW_CNT_EN
                        r_mul_cnt   <= r_mul_cnt + 1'b1;
`endif
                    end

                    S_MUL_WAIT: begin
                        if (mul_done) begin
                            r_result <= mul_p;
                            if (r_k == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_k     <= r_k - c_k_one;
                                r_state <= S_SQ_REQ;
                            end
                        end
                    end

                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    // The request strobe is registered, so an abort landing in the same
    // cycle must suppress it here or the multiplier would still launch.
    assign mul_start = r_mul_start & ~abort;
`ifdef E_CALC_POW_CNT_EN
    assign mul_cnt = r_mul_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_e_calc_pow.sv
`default_nettype none
// ============================================================================
// Module      : tb_e_calc_pow
// Description : Self-checking bench for e_calc_pow with a variable-latency
//               truncating fixed-point multiplier model and a plain
//               arithmetic power reference.
// Revision    : 1.0  initial release
// ============================================================================
module tb_e_calc_pow;

    localparam int WORD_W = 16;
    localparam int WORDS  = 32;
    localparam int EXP_W  = 16;
    localparam int OP_W   = WORD_W * WORDS;
    localparam int FRAC   = OP_W - WORD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [EXP_W-1:0]  exp_in = '0;
    logic [OP_W-1:0]   base_in = '0;
    logic              busy;
    logic              done;
    logic [OP_W-1:0]   result;
    logic              mul_start;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic              mul_done = 1'b0;
    logic [OP_W-1:0]   mul_p = '0;
`ifdef E_CALC_POW_CNT_EN
    logic [EXP_W+1:0]  mul_cnt;
`endif

    int total = 0;
    int bad   = 0;

    e_calc_pow #(.WORD_W(WORD_W), .WORDS(WORDS), .EXP_W(EXP_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .exp_in    (exp_in),
        .base_in   (base_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p)
`ifdef E_CALC_POW_CNT_EN
        ,
        .mul_cnt   (mul_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [OP_W-1:0] one_val();
        logic [OP_W-1:0] v;
        v = '0;
        v[FRAC] = 1'b1;
        return v;
    endfunction

    function automatic logic [OP_W-1:0] fmul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [2*OP_W-1:0] p;
        p = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
        p = p >> FRAC;
        return p[OP_W-1:0];
    endfunction

    // r = 1; for each bit MSB-first: r = r*r, then r = r*b when the bit is set.
    // Products with 1.0 are exact, so this equals the engine's sequence.
    function automatic logic [OP_W-1:0] ref_pow(input logic [EXP_W-1:0] e, input logic [OP_W-1:0] b);
        logic [OP_W-1:0] r;
        r = one_val();
        for (int i = EXP_W - 1; i >= 0; i--) begin
            r = fmul(r, r);
            if (e[i]) r = fmul(r, b);
        end
        return r;
    endfunction

    function automatic int ref_nmul(input logic [EXP_W-1:0] e);
        int bl;
        if (e == '0) return 0;
        bl = 0;
        for (int i = 0; i < EXP_W; i++) if (e[i]) bl = i + 1;
        return (bl - 1) + ($countones(e) - 1);
    endfunction

    // Expected op order encoded 2 bits per op: 1 = square, 2 = multiply.
    function automatic logic [63:0] ref_seq(input logic [EXP_W-1:0] e);
        logic [63:0] code;
        bit seen;
        code = '0;
        seen = 1'b0;
        for (int i = EXP_W - 1; i >= 0; i--) begin
            if (seen) begin
                code = (code << 2) | 64'd1;
                if (e[i]) code = (code << 2) | 64'd2;
            end else if (e[i]) begin
                seen = 1'b1;
            end
        end
        return code;
    endfunction

    // ------------------------------------------------------ multiplier model
    int          force_lat = 0;
    logic        mm_busy = 1'b0;
    int          mm_cnt = 0;
    logic [OP_W-1:0] mm_a = '0;
    logic [OP_W-1:0] mm_b = '0;
    int          n_mst = 0;
    int          op_log [0:1023];

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (!rst_n) begin
            mm_busy <= 1'b0;
        end else begin
            if (mm_busy) begin
                if (mm_cnt <= 1) begin
                    mul_done <= 1'b1;
                    mul_p    <= fmul(mm_a, mm_b);
                    mm_busy  <= 1'b0;
                end else begin
                    mm_cnt <= mm_cnt - 1;
                end
            end
            if (mul_start) begin
                mm_a    <= mul_a;
                mm_b    <= mul_b;
                mm_cnt  <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 20));
                mm_busy <= 1'b1;
                op_log[n_mst % 1024] <= (mul_a === mul_b) ? 1 : 2;
                n_mst   <= n_mst + 1;
            end
        end
    end

    // ------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic kick(input logic [EXP_W-1:0] e, input logic [OP_W-1:0] b);
        @(posedge clk); #1;
        start   = 1'b1;
        exp_in  = e;
        base_in = b;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Runs one operation; poke > 0 re-pulses start with junk at that cycle.
    task automatic run_op(input string tag, input logic [EXP_W-1:0] e,
                          input logic [OP_W-1:0] b, input int poke, output int lat);
        int n0;
        n0 = n_mst;
        kick(e, b);
        lat = 1;
        check({tag, "_busy"}, busy, 1'b1);
        while (!done && lat < 4000) begin
            if (lat == poke) begin
                start = 1'b1; exp_in = ~e; base_in = ~b;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_res"}, result, ref_pow(e, b));
        check({tag, "_nmul"}, n_mst - n0, ref_nmul(e));
`ifdef E_CALC_POW_CNT_EN
        check({tag, "_cnt"}, mul_cnt, ref_nmul(e));
`endif
        @(posedge clk); #1;
        check({tag, "_pulse"}, {done, busy}, 2'b00);
    endtask

    function automatic logic [OP_W-1:0] rnd_base();
        logic [OP_W-1:0] v;
        for (int i = 0; i < OP_W / 32; i++) v[i*32 +: 32] = $urandom;
        v[OP_W-1 -: WORD_W] = WORD_W'($urandom_range(0, 2));
        return v;
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin : main
        int lat;
        int n0;
        int found;
        int dn;
        int md;
        logic [63:0] code;
        logic [OP_W-1:0] b;
        logic [OP_W-1:0] part;
        logic [EXP_W-1:0] e;

        #12;
        check("rst_ctl", {busy, done, mul_start}, 3'b000);
        check("rst_res", result, '0);
        check("rst_ma", mul_a, '0);
        check("rst_mb", mul_b, '0);
        @(negedge clk); rst_n = 1'b1;

        // exp = 0 -> 1.0 after EXP_W+1 cycles
        run_op("e0", '0, rnd_base(), 0, lat);
        check("e0_lat", lat, EXP_W + 1);

        // exp = 1 -> base unchanged
        b = one_val();
        b[OP_W-WORD_W-1] = 1'b1;
        run_op("e1", 16'd1, b, 0, lat);
        check("e1_val", result, b);
        check("e1_lat", lat, EXP_W + 1);

        // exp = 13 -> S,M,S,S,M
        b = one_val();
        b[FRAC-4] = 1'b1;
        n0 = n_mst;
        run_op("e13", 16'd13, b, 0, lat);
        code = '0;
        for (int i = 0; i < n_mst - n0 && i < 32; i++)
            code = (code << 2) | 64'(op_log[(n0 + i) % 1024]);
        check("e13_seq", code, ref_seq(16'd13));

        // exp = 0x8000 -> pure repeated squaring
        b = one_val();
        b[FRAC-15] = 1'b1;
        run_op("e8000", 16'h8000, b, 0, lat);

        // start while busy is ignored
        b = rnd_base();
        run_op("poke", 16'd13, b, 5, lat);

        // random exponents and bases
        for (int t = 0; t < 8; t++) begin
            e = (t < 4) ? EXP_W'($urandom_range(1, 255)) : EXP_W'($urandom);
            run_op("rnd", e, rnd_base(), 0, lat);
        end

        // abort during MUL_WAIT, then a late mul_done
        force_lat = 20;
        kick(16'd13, rnd_base());
        found = 0;
        part  = '0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(posedge clk); #1;
            if (mul_start && (mul_a !== mul_b)) begin
                found = 1;
                part  = mul_a;
            end
        end
        check("ab_find", found, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_ctl", {busy, mul_start}, 2'b00);
        dn = 0;
        md = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dn = 1;
            if (mul_done) md = 1;
        end
        check("ab_nodone", dn, 0);
        check("ab_late", md, 1);
        check("ab_idle", busy, 1'b0);
        check("ab_hold", result, part);
        force_lat = 0;
        run_op("ab_new", 16'd13, rnd_base(), 0, lat);

        // reset in SQ_WAIT
        force_lat = 20;
        kick(16'h8000, rnd_base());
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(posedge clk); #1;
            if (mul_start) found = 1;
        end
        check("rs_find", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_ctl", {busy, done, mul_start}, 3'b000);
        check("rs_res", result, '0);
        @(posedge clk); #1;
        check("rs_ops", {mul_a, mul_b} == '0, 1'b1);
        check("rs_ctl2", {busy, done, mul_start}, 3'b000);
        @(negedge clk); rst_n = 1'b1;
        force_lat = 0;
        run_op("rs_new", EXP_W'($urandom), rnd_base(), 0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
